ascon128a_dec_sched: RTL
========================

Name: ascon128a_dec_sched

Overview:
Control-only sequencer for ASCON-128a decryption of the ciphertext phase plus finalization.
- Splits a ciphertext of ct_len bytes into 16-byte rate blocks and requests each block from the PS-side buffer.
- Tells the datapath how many bytes are valid and where the 0x80 pad goes.
- Schedules the shared permutation engine for p8 (between blocks) and p12 (finalization).
- Carries no 320-bit state; it sits between the AXI register front-end and the state/permutation datapath.

Parameters:
- LEN_W, 32, width of ct_len and the remaining-byte counter.
- RATE_BYTES, 16, rate in bytes (ASCON-128a).
- ROUNDS_B, 8, rounds between ciphertext blocks.
- ROUNDS_A, 12, rounds for finalization.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- ct_len  in  LEN_W  ciphertext length in bytes, tag excluded; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- blk_req  out  1  block request to the buffer/datapath.
- blk_ack  in  1  block present and absorbed by the datapath this cycle.
- blk_bytes  out  5  valid bytes in the current block, 0..16; 0 means pad-only block.
- blk_last  out  1  current block is the final (padded) block.
- blk_idx  out  LEN_W-4  zero-based block index.
- perm_start  out  1  one-cycle pulse to the permutation engine.
- perm_rounds  out  4  ROUNDS_B or ROUNDS_A; held stable while waiting.
- perm_done  in  1  one-cycle completion pulse from the permutation engine.
- key_xor  out  1  one-cycle pulse: datapath XORs key into state, pre-p12.
- tag_match  in  1  datapath tag comparison result, valid when sampled.
- done  out  1  one-cycle completion pulse.
- auth_ok  out  1  tag_match sampled in the done cycle; held until next accepted start.

Behaviour:
- Reset: state IDLE; every output 0; counters 0. Reset mid-operation aborts immediately with no completion pulse.
- All outputs registered. rem = remaining bytes, LEN_W bits.

State IDLE:
- start=1: rem<=ct_len, blk_idx<=0, auth_ok<=0, busy<=1.
- Next state is PADONLY if ct_len==0, else FETCH.

State FETCH:
- blk_req=1; blk_bytes=min(rem,16); blk_last=(rem<16).
- Waits on blk_ack; blk_req stays high and outputs stay stable until blk_ack.
- On blk_ack:
  - rem<16: go to FINAL_K. Partial final block: pad is inside the block, no p8.
  - Otherwise: rem<=rem-16, go to PB, blk_idx increments on perm_done.

State PB:
- perm_start pulses on entry cycle, perm_rounds=ROUNDS_B; wait perm_done.
- On perm_done: next state is PADONLY if rem==0, else FETCH.

State PADONLY:
- blk_req=1, blk_bytes=0, blk_last=1; wait blk_ack, then go to FINAL_K.
- Covers both empty ciphertext and a ciphertext length that is a multiple of 16 (pad 0x80 at byte 0).

State FINAL_K:
- key_xor pulses for one cycle, then go to PA.

State PA:
- perm_start pulses, perm_rounds=ROUNDS_A; wait perm_done, then go to TAG.

State TAG:
- One cycle: datapath has applied the second key XOR. Sample tag_match into auth_ok.
- done=1, busy<=0, go to IDLE.

Boundary rules:
- perm_done or blk_ack outside its waiting state is ignored.
- blk_ack in the same cycle as blk_req rising is accepted.
- start while busy is ignored; no queueing.
- perm_done coincident with reset has no effect.
- Minimum latency start→done, zero-wait handshakes, ct_len=5: IDLE→FETCH→FINAL_K→PA→(perm latency)→TAG. done occurs 4 cycles plus permutation latency after start.
- ct_len above 2^LEN_W-16: rem arithmetic is exact, no wrap. The subtract happens only when rem≥16.

Decomposition:
- Shared package ascon_pkg holds:
  - state enum (IDLE, FETCH, PB, PADONLY, FINAL_K, PA, TAG);
  - constants RATE_BYTES, ROUNDS_A, ROUNDS_B;
  - pad byte 8'h80.
- One natural sub-module: ascon_blk_counter, holding rem/blk_idx, the min(rem,16) computation and the last flag. The FSM stays in the top.

Test Plan:
- ct_len=0 → no FETCH. One PADONLY request (blk_bytes=0, blk_last=1), key_xor, one perm_start with rounds=12, done; total 0 p8 starts.
- ct_len=5 → one request (blk_bytes=5, blk_last=1), no p8, one p12. With tag_match=1, auth_ok=1 at done.
- ct_len=16 → request (16, last=0), p8, PADONLY (0, last=1), p12. Sequence of perm_rounds = 8,12.
- ct_len=33 → requests (16,0,idx0), (16,0,idx1), (1,1,idx2). perm_rounds = 8,8,12. tag_match=0 → auth_ok=0.
- start pulsed during PB of a ct_len=40 run → ignored; exactly one done; blk_idx sequence 0,1,2.
- rst low while waiting in PA → all outputs 0 next edge. No done. A new start with ct_len=5 then completes normally.

Source files
------------

// File: rtl/ascon128a_dec_sched_pkg.sv
// Shared constants and state encoding for the ASCON-128a decryption sequencer.
package ascon_pkg;

  localparam int unsigned RATE_BYTES = 16;
  localparam logic [3:0]  ROUNDS_A   = 4'd12;
  localparam logic [3:0]  ROUNDS_B   = 4'd8;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PB      = 3'd2,
    PADONLY = 3'd3,
    FINAL_K = 3'd4,
    PA      = 3'd5,
    TAG     = 3'd6
  } state_e;

endpackage

// File: rtl/ascon128a_dec_sched_if.sv
// Handshake bundle between the register front-end, block buffer, permutation engine and sequencer.
interface ascon128a_dec_sched_if #(
  parameter int LEN_W = 32
);
  logic             start;
  logic [LEN_W-1:0] ct_len;
  logic             busy;
  logic             blk_req;
  logic             blk_ack;
  logic [4:0]       blk_bytes;
  logic             blk_last;
  logic [LEN_W-5:0] blk_idx;
  logic             perm_start;
  logic [3:0]       perm_rounds;
  logic             perm_done;
  logic             key_xor;
  logic             tag_match;
  logic             done;
  logic             auth_ok;

  modport master (
    output start, ct_len, blk_ack, perm_done, tag_match,
    input  busy, blk_req, blk_bytes, blk_last, blk_idx, perm_start, perm_rounds,
           key_xor, done, auth_ok
  );

  modport slave (
    input  start, ct_len, blk_ack, perm_done, tag_match,
    output busy, blk_req, blk_bytes, blk_last, blk_idx, perm_start, perm_rounds,
           key_xor, done, auth_ok
  );
endinterface

// File: rtl/ascon128a_dec_sched_blk_counter.sv
// Remaining-byte and block-index bookkeeping; exposes the byte count and last flag
// the next block request will carry.
module ascon_blk_counter
  import ascon_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub,
  input  logic             inc,
  input  logic [LEN_W-1:0] ct_len,
  output logic             rem_zero,
  output logic             rem_last,
  output logic [4:0]       bytes_nxt,
  output logic             last_nxt,
  output logic [LEN_W-5:0] blk_idx
);

  localparam logic [LEN_W-1:0] RATE_L = LEN_W'(RATE_BYTES);

  logic [LEN_W-1:0] rem_r;
  logic [LEN_W-1:0] rem_nxt_s;
  logic [LEN_W-5:0] idx_r;

  // Subtract only when a full block remains, so lengths near the top of the range never wrap
  always_comb begin
    rem_nxt_s = rem_r;
    if (load) begin
      rem_nxt_s = ct_len;
    end else if (sub && (rem_r >= RATE_L)) begin
      rem_nxt_s = rem_r - RATE_L;
    end else begin
      rem_nxt_s = rem_r;
    end
  end

  // Block descriptor for the request that follows this cycle
  always_comb begin
    last_nxt  = (rem_nxt_s < RATE_L);
    bytes_nxt = 5'(RATE_BYTES);
    if (last_nxt) begin
      bytes_nxt = rem_nxt_s[4:0];
    end else begin
      bytes_nxt = 5'(RATE_BYTES);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r <= '0;
      idx_r <= '0;
    end else begin
      rem_r <= rem_nxt_s;
      if (load) begin
        idx_r <= '0;
      end else if (inc) begin
        idx_r <= idx_r + {{(LEN_W-5){1'b0}}, 1'b1};
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign rem_zero = (rem_r == '0);
  assign rem_last = (rem_r < RATE_L);
  assign blk_idx  = idx_r;

endmodule

// File: rtl/ascon128a_dec_sched.sv
// ASCON-128a decryption control sequencer: ciphertext block fetch, p8/p12 scheduling,
// key XOR and tag sampling. All outputs come straight from registers.
module ascon128a_dec_sched
  import ascon_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  ascon128a_dec_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_FETCH   = FETCH;
  localparam logic [2:0] S_PB      = PB;
  localparam logic [2:0] S_PADONLY = PADONLY;
  localparam logic [2:0] S_FINAL_K = FINAL_K;
  localparam logic [2:0] S_PA      = PA;
  localparam logic [2:0] S_TAG     = TAG;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             load_s;
  logic             sub_s;
  logic             inc_s;
  logic             rem_zero_s;
  logic             rem_last_s;
  logic [4:0]       bytes_nxt_s;
  logic             last_nxt_s;
  logic [LEN_W-5:0] blk_idx_s;

  logic             busy_r;
  logic             blk_req_r;
  logic [4:0]       blk_bytes_r;
  logic             blk_last_r;
  logic             perm_start_r;
  logic [3:0]       perm_rounds_r;
  logic             key_xor_r;
  logic             done_r;
  logic             auth_ok_r;

  ascon_blk_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .sub       (sub_s),
    .inc       (inc_s),
    .ct_len    (bus.ct_len),
    .rem_zero  (rem_zero_s),
    .rem_last  (rem_last_s),
    .bytes_nxt (bytes_nxt_s),
    .last_nxt  (last_nxt_s),
    .blk_idx   (blk_idx_s)
  );

  // Next-state and counter control
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    sub_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = (bus.ct_len == '0) ? S_PADONLY : S_FETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        // A partial block already carries the pad, so it goes straight to finalization
        if (bus.blk_ack) begin
          if (rem_last_s) begin
            state_nxt_s = S_FINAL_K;
          end else begin
            sub_s       = 1'b1;
            state_nxt_s = S_PB;
          end
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_PB: begin
        if (bus.perm_done) begin
          inc_s       = 1'b1;
          state_nxt_s = rem_zero_s ? S_PADONLY : S_FETCH;
        end else begin
          state_nxt_s = S_PB;
        end
      end
      S_PADONLY: begin
        if (bus.blk_ack) begin
          state_nxt_s = S_FINAL_K;
        end else begin
          state_nxt_s = S_PADONLY;
        end
      end
      S_FINAL_K: state_nxt_s = S_PA;
      S_PA: begin
        if (bus.perm_done) begin
          state_nxt_s = S_TAG;
        end else begin
          state_nxt_s = S_PA;
        end
      end
      S_TAG:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and output registers, each output decoded from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      busy_r        <= 1'b0;
      blk_req_r     <= 1'b0;
      blk_bytes_r   <= 5'd0;
      blk_last_r    <= 1'b0;
      perm_start_r  <= 1'b0;
      perm_rounds_r <= 4'd0;
      key_xor_r     <= 1'b0;
      done_r        <= 1'b0;
      auth_ok_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
      blk_req_r    <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_PADONLY);
      blk_bytes_r  <= (state_nxt_s == S_FETCH) ? bytes_nxt_s : 5'd0;
      blk_last_r   <= ((state_nxt_s == S_FETCH) && last_nxt_s) || (state_nxt_s == S_PADONLY);
      perm_start_r <= ((state_nxt_s == S_PB) && (state_r != S_PB)) ||
                      ((state_nxt_s == S_PA) && (state_r != S_PA));
      key_xor_r    <= (state_nxt_s == S_FINAL_K);
      done_r       <= (state_r == S_TAG);
      if (state_nxt_s == S_PB) begin
        perm_rounds_r <= ROUNDS_B;
      end else if (state_nxt_s == S_PA) begin
        perm_rounds_r <= ROUNDS_A;
      end else begin
        perm_rounds_r <= 4'd0;
      end
      // auth_ok reports the last completed run until a new one is accepted
      if (state_r == S_TAG) begin
        auth_ok_r <= bus.tag_match;
      end else if ((state_r == S_IDLE) && bus.start) begin
        auth_ok_r <= 1'b0;
      end else begin
        auth_ok_r <= auth_ok_r;
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.blk_req     = blk_req_r;
  assign bus.blk_bytes   = blk_bytes_r;
  assign bus.blk_last    = blk_last_r;
  assign bus.blk_idx     = blk_idx_s;
  assign bus.perm_start  = perm_start_r;
  assign bus.perm_rounds = perm_rounds_r;
  assign bus.key_xor     = key_xor_r;
  assign bus.done        = done_r;
  assign bus.auth_ok     = auth_ok_r;

endmodule
